// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, small PC/instruction
// buffer toward the decoder, and redirect-driven flush/restart.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY
);

    localparam int              PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CAP = CW'(DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc_p0;
    logic [63:0]   buf_p1 [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   head_p1;
    logic          vld_p1;
    logic          accept;
    logic          push;
    logic          pop;

    // Request stage: credit check counts only buffered words; issue is only legal from RUN.
    assign IMEM_REQ  = (state == ST_RUN) && (count < CAP) && !REDIRECT && !RST;
    assign IMEM_ADDR = fetch_pc;
    assign accept    = IMEM_REQ && IMEM_READY;

    assign vld_p1 = (count != '0);
    assign push   = (state == ST_WAIT) && IMEM_RVALID && !REDIRECT;
    assign pop    = vld_p1 && INSTR_READY && !REDIRECT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
            state    <= ST_RUN;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (REDIRECT) begin
            // A response still owed by memory must be swallowed, not buffered.
            fetch_pc <= REDIRECT_PC & ~32'h3;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            if ((state == ST_WAIT || state == ST_DRAIN) && !IMEM_RVALID)
                state <= ST_DRAIN;
            else
                state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT:  if (IMEM_RVALID) state <= ST_RUN;
                ST_DRAIN: if (IMEM_RVALID) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) req_pc_p0 <= fetch_pc;
    end

    // Buffer stage: {pc, instruction} per entry.
    always_ff @(posedge CLK) begin
        if (push && !RST) buf_p1[wr_ptr] <= {req_pc_p0, IMEM_RDATA};
    end

    assign head_p1     = buf_p1[rd_ptr];
    assign INSTR_VALID = vld_p1;
    assign INSTRUCTION = vld_p1 ? head_p1[31:0]  : 32'h0;
    assign INSTR_PC    = vld_p1 ? head_p1[63:32] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with programmable latency and a
// scoreboard queue of expected {pc, instruction} pairs checked on every pop.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY = 1'b1;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    logic [63:0] exp_q [$];

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INSTRUCTION(INSTRUCTION), .INSTR_PC(INSTR_PC),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    // Memory responder: data = address ^ 0xA5A5_0000, RVALID L cycles after acceptance.
    bit          mbusy = 0;
    int          mcnt = 0;
    logic [31:0] maddr = 32'h0;
    always @(posedge CLK) begin
        if (RST) begin
            mbusy = 0;
            IMEM_RVALID <= 1'b0;
        end else begin
            if (IMEM_RVALID) begin
                IMEM_RVALID <= 1'b0;
                mbusy = 0;
            end else if (mbusy) begin
                mcnt--;
                if (mcnt == 0) begin
                    IMEM_RVALID <= 1'b1;
                    IMEM_RDATA  <= maddr ^ 32'hA5A5_0000;
                end
            end
            if (IMEM_REQ && IMEM_READY) begin
                mbusy = 1;
                maddr = IMEM_ADDR;
                mcnt  = lat - 1;
                if (mcnt == 0) begin
                    IMEM_RVALID <= 1'b1;
                    IMEM_RDATA  <= IMEM_ADDR ^ 32'hA5A5_0000;
                end
            end
        end
    end

    // Scoreboard monitor: every consumed instruction must match the queue head.
    always @(negedge CLK) begin
        if (!RST && INSTR_VALID && INSTR_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none", INSTR_PC, INSTRUCTION);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", INSTR_PC, e[63:32]);
                chk("sb_instr", INSTRUCTION, e[31:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        RST = 1'b1;
        REDIRECT = 1'b0;
        INSTR_READY = 1'b0;
        IMEM_READY = 1'b1;
        #3;
        chk("req_low_in_reset", 32'(IMEM_REQ), 32'd0);
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: streaming at 1-cycle latency
        lat = 1;
        do_reset();
        push_exp(32'h0, 32'hA5A5_0000);
        push_exp(32'h4, 32'hA5A5_0004);
        push_exp(32'h8, 32'hA5A5_0008);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) next_cycle();
            INSTR_READY = 1'b1;
            #3;
            if (c == 0) begin
                chk("rst_valid", 32'(INSTR_VALID), 32'd0);
                chk("rst_instr", INSTRUCTION, 32'h0);
                chk("rst_pc", INSTR_PC, 32'h0);
            end
            chk("t1_req", 32'(IMEM_REQ), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 0) chk("t1_addr", IMEM_ADDR, 32'(c * 2));
            if (c == 1) chk("t1_valid_c1", 32'(INSTR_VALID), 32'd0);
            if (c == 2) chk("t1_valid_c2", 32'(INSTR_VALID), 32'd1);
        end

        // Test 2: back-pressure fills both entries, then drain
        do_reset();
        push_exp(32'h0, 32'hA5A5_0000);
        push_exp(32'h4, 32'hA5A5_0004);
        push_exp(32'h8, 32'hA5A5_0008);
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) next_cycle();
            INSTR_READY = (c >= 8);
            #3;
            if (c >= 4 && c <= 7) begin
                chk("t2_req_full", 32'(IMEM_REQ), 32'd0);
                chk("t2_hold_pc", INSTR_PC, 32'h0);
                chk("t2_hold_instr", INSTRUCTION, 32'hA5A5_0000);
            end
            if (c == 9) begin
                chk("t2_resume_req", 32'(IMEM_REQ), 32'd1);
                chk("t2_resume_addr", IMEM_ADDR, 32'h8);
            end
        end

        // Test 3: redirect with a full buffer in RUN
        do_reset();
        push_exp(32'h100, 32'hA5A5_0100);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) next_cycle();
            REDIRECT = (c == 5);
            REDIRECT_PC = 32'h103;
            INSTR_READY = (c >= 6);
            #3;
            if (c == 4) chk("t3_full_valid", 32'(INSTR_VALID), 32'd1);
            if (c == 5) chk("t3_req_redirect", 32'(IMEM_REQ), 32'd0);
            if (c == 6) begin
                chk("t3_flushed", 32'(INSTR_VALID), 32'd0);
                chk("t3_addr", IMEM_ADDR, 32'h100);
                chk("t3_req", 32'(IMEM_REQ), 32'd1);
            end
        end

        // Test 4: redirect while a 3-cycle-latency fetch of 0x8 is outstanding
        lat = 3;
        do_reset();
        push_exp(32'h0, 32'hA5A5_0000);
        push_exp(32'h4, 32'hA5A5_0004);
        push_exp(32'h200, 32'hA5A5_0200);
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) next_cycle();
            INSTR_READY = 1'b1;
            REDIRECT = (c == 9);
            REDIRECT_PC = 32'h200;
            #3;
            if (c == 8) chk("t4_addr8", IMEM_ADDR, 32'h8);
            if (c == 10 || c == 11) chk("t4_drain_req", 32'(IMEM_REQ), 32'd0);
            if (c == 12) begin
                chk("t4_addr", IMEM_ADDR, 32'h200);
                chk("t4_req", 32'(IMEM_REQ), 32'd1);
                chk("t4_no_stale", 32'(INSTR_VALID), 32'd0);
            end
        end

        // Test 5: redirect coincident with the response
        lat = 1;
        do_reset();
        push_exp(32'h40, 32'hA5A5_0040);
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) next_cycle();
            INSTR_READY = 1'b1;
            REDIRECT = (c == 1);
            REDIRECT_PC = 32'h40;
            #3;
            if (c == 1) chk("t5_rvalid", 32'(IMEM_RVALID), 32'd1);
            if (c == 2) begin
                chk("t5_req", 32'(IMEM_REQ), 32'd1);
                chk("t5_addr", IMEM_ADDR, 32'h40);
                chk("t5_dropped", 32'(INSTR_VALID), 32'd0);
            end
        end

        // Test 6: memory stall, reset during WAIT, then fetch across the address wrap
        do_reset();
        push_exp(32'hFFFF_FFFC, 32'h5A5A_FFFC);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) next_cycle();
            IMEM_READY = (c >= 5);
            RST = (c == 6);
            REDIRECT = (c == 8);
            REDIRECT_PC = 32'hFFFF_FFFF;
            INSTR_READY = (c >= 9 && c <= 11);
            #3;
            if (c <= 4) begin
                chk("t6_stall_req", 32'(IMEM_REQ), 32'd1);
                chk("t6_stall_addr", IMEM_ADDR, 32'h0);
            end
            if (c == 7) begin
                chk("t6_post_rst_valid", 32'(INSTR_VALID), 32'd0);
                chk("t6_post_rst_addr", IMEM_ADDR, 32'h0);
                chk("t6_post_rst_req", 32'(IMEM_REQ), 32'd1);
            end
            if (c == 9) chk("t6_wrap_from", IMEM_ADDR, 32'hFFFF_FFFC);
            if (c == 11) chk("t6_wrap_to", IMEM_ADDR, 32'h0);
        end

        next_cycle();
        next_cycle();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
